lsu_mem_seq: RTL
================

Name: lsu_mem_seq

Overview:
- Load/store sequencer that sits between the execute/memory stage and the 32-bit byte-lane data RAM.
- Accepts one request at a time over a valid/ready handshake and drives registered RAM enable, address, byte-lane write enables and lane-aligned write data.
- Returns sign- or zero-extended load data.
- Splits misaligned halfword and word accesses into two aligned RAM accesses.

Parameters:
- AW, 32, byte-address width; RAM word address is AW-2 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_we  in  1  1 = store, 0 = load
- req_mode  in  3  one-hot size: [2] word, [1] half, [0] byte
- req_unsigned  in  1  zero-extend the load result
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request rejected, valid only with rsp_valid
- ram_en  out  1  RAM access strobe
- ram_we  out  4  byte-lane write enables, lane k = bits [8k+7:8k]
- ram_addr  out  AW-2  RAM word address
- ram_wdata  out  32  lane-aligned write data
- ram_rdata  in  32  RAM read data, valid one cycle after ram_en

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset: state IDLE; ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
- req_ready = (state==IDLE) & ~rst.
- Accept: req_valid & req_ready at a rising edge. Latch we, mode, unsigned, cs = addr[1:0], word address and rotated write data.
- Rotated write data = req_wdata rotated left by 8*cs. The same rotated word is used for both halves of a split access.
- States:
  - IDLE: on accept, go to ERR if the access is an error, else to A1.
  - A1: ram_en=1, ram_addr = word address, ram_we = mask1 if store else 0. Go to A2 if the access is split, else to RESP.
  - A2: ram_en=1, ram_addr = word address + 1, wrapping modulo 2^(AW-2); ram_we = mask2 if store else 0. Capture ram_rdata from A1 into lo_buf. Go to RESP.
  - RESP: rsp_valid=1, rsp_err=0, rsp_rdata driven. Go to IDLE.
  - ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0, no RAM access. Go to IDLE.
- ram_en and ram_we are 0 in every state other than A1 and A2.
- Error conditions:
  - req_mode not exactly one-hot.
  - Misaligned access while MISALIGN_SPLIT_EN is undefined.
- Split conditions: half with cs=3; word with cs!=0.
- Lane masks:
  - byte: mask1 = lane cs.
  - half, cs<=2: mask1 = lanes cs and cs+1.
  - half, cs=3: mask1 = lane 3, mask2 = lane 0.
  - word: mask1 = lanes cs..3, mask2 = lanes 0..cs-1.
- Load assembly in RESP:
  - Merge word = lanes >= cs taken from lo_buf (split) or ram_rdata (unsplit), lanes < cs taken from ram_rdata.
  - Rotate the merged word right by 8*cs.
  - Take bits [7:0] for byte, [15:0] for half, [31:0] for word.
  - Sign-extend unless req_unsigned.
- Latency from accept edge to rsp_valid cycle: aligned = 2 cycles, split = 3 cycles, error = 1 cycle.
- Throughput: next request can be accepted in the cycle after RESP/ERR.
- Reset mid-operation: rst wins in the same edge. The sequencer returns to IDLE with no further ram_en and no rsp_valid for the aborted request.

Optional Feature:
- Macro: MISALIGN_SPLIT_EN.
- Defined: misaligned half/word accesses are split into two RAM accesses as specified above.
- Undefined: A2 is unreachable. Misaligned half/word goes IDLE->ERR with rsp_err=1 and no RAM access.

Decomposition:
- Package lsu_pkg holds:
  - MODE_W=3'b100, MODE_H=3'b010, MODE_B=3'b001.
  - State enum {IDLE, A1, A2, RESP, ERR}.
  - Function that rotates a 32-bit word by a lane count.
- Sub-module lsu_lane_mask: combinational (mode, cs, second) -> 4-bit lane mask; shared by the store and load merge logic.

Test Plan:
- Aligned word store, addr 0x100, wdata 0xDEADBEEF -> edge+1: ram_en=1, ram_addr=0x40, ram_we=4'b1111, ram_wdata=0xDEADBEEF; edge+2: rsp_valid=1, rsp_err=0.
- Byte load, addr 0x103, RAM word 0x80112233, signed -> rsp_rdata=0xFFFFFF80; same with req_unsigned=1 -> 0x00000080.
- Half store, addr 0x107, wdata 0x0000A1B2 (split build) -> A1: ram_addr=0x41, ram_we=4'b1000, byte3=0xB2; A2: ram_addr=0x42, ram_we=4'b0001, byte0=0xA1; rsp at edge+3.
- Word load, addr 0x0FE, RAM[0x3F]=0x4433xxxx, RAM[0x40]=0xxxxx6655 (split build) -> rsp_rdata=0x66554433.
- Word address wrap: split word load at byte addr (2^AW)-2, AW=32 -> second access ram_addr=0.
- req_mode=3'b011 -> rsp_valid with rsp_err=1 one cycle after accept, ram_en never asserted. Also: assert rst during A2 of a split store -> no ram_en the following cycle, no rsp_valid, req_ready=1 after rst deasserts.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: size encodings, state type
// and a byte-lane rotate helper.
package lsu_pkg;

  localparam logic [2:0] MODE_W = 3'b100;
  localparam logic [2:0] MODE_H = 3'b010;
  localparam logic [2:0] MODE_B = 3'b001;

  typedef enum logic [2:0] {IDLE, A1, A2, RESP, ERR} state_e;

  // Rotate a 32-bit word left by a whole number of byte lanes.
  function automatic logic [31:0] rotl_lanes(input logic [31:0] data, input logic [1:0] lanes);
    logic [63:0] dbl;
    dbl = {data, data} << {lanes, 3'b000};
    return dbl[63:32];
  endfunction

endpackage

// File: rtl/lsu_lane_mask.sv
// Byte-lane mask for the first or second RAM access of a request, derived from
// the access size and the byte offset within the word.
module lsu_lane_mask
  import lsu_pkg::*;
(
  input  logic [2:0] mode,
  input  logic [1:0] cs,
  input  logic       second,
  output logic [3:0] mask
);

  logic [7:0] base;
  logic [7:0] spread;

  // Lanes that spill past lane 3 land in the upper nibble: that is the second access.
  always_comb begin
    base = 8'h00;
    case (mode)
      MODE_B:  base = 8'h01;
      MODE_H:  base = 8'h03;
      MODE_W:  base = 8'h0F;
      default: base = 8'h00;
    endcase
    spread = base << cs;
    mask   = second ? spread[7:4] : spread[3:0];
  end

endmodule

// File: rtl/lsu_mem_seq.sv
// Load/store sequencer between the memory stage and a 32-bit byte-lane RAM.
// Build option MISALIGN_SPLIT_EN: split misaligned half/word accesses in two.
//
// state | meaning
// IDLE  | ready for a request
// A1    | first (or only) RAM access
// A2    | second RAM access of a split request, capture first read data
// RESP  | completion pulse with load data
// ERR   | completion pulse flagging a rejected request
module lsu_mem_seq
  import lsu_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_mode,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-3:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    mode_q, mode_d;
  logic          uns_q, uns_d;
  logic [1:0]    cs_q, cs_d;
  logic [AW-3:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   lo_buf_q, lo_buf_d;

  logic          accept;
  logic [1:0]    req_cs;
  logic          mode_ok;
  logic          req_err;
  logic          split;
  logic [3:0]    mask1, mask2;
  logic [3:0]    lo_sel;
  logic [31:0]   merged, aligned, load_data;

  assign req_ready = (state_q == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  assign req_cs    = req_addr[1:0];
  assign mode_ok   = (req_mode == MODE_W) | (req_mode == MODE_H) | (req_mode == MODE_B);

`ifdef MISALIGN_SPLIT_EN
  assign req_err = ~mode_ok;
`else
  logic req_misal;
  assign req_misal = ((req_mode == MODE_H) & req_cs[0]) | ((req_mode == MODE_W) & (req_cs != 2'd0));
  assign req_err   = ~mode_ok | req_misal;
`endif

  assign split = ((mode_q == MODE_H) & (cs_q == 2'd3)) | ((mode_q == MODE_W) & (cs_q != 2'd0));

  lsu_lane_mask u_mask1 (.mode(mode_q), .cs(cs_q), .second(1'b0), .mask(mask1));
  lsu_lane_mask u_mask2 (.mode(mode_q), .cs(cs_q), .second(1'b1), .mask(mask2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      mode_q   <= 3'b000;
      uns_q    <= 1'b0;
      cs_q     <= 2'd0;
      waddr_q  <= '0;
      wdata_q  <= 32'h0;
      lo_buf_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      mode_q   <= mode_d;
      uns_q    <= uns_d;
      cs_q     <= cs_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      lo_buf_q <= lo_buf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    mode_d   = mode_q;
    uns_d    = uns_q;
    cs_d     = cs_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    lo_buf_d = lo_buf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = req_err ? ERR : A1;
          we_d    = req_we;
          mode_d  = req_mode;
          uns_d   = req_unsigned;
          cs_d    = req_cs;
          waddr_d = req_addr[AW-1:2];
          wdata_d = rotl_lanes(req_wdata, req_cs);
        end
      end
      A1:      state_d = split ? A2 : RESP;
      A2: begin
        state_d  = RESP;
        lo_buf_d = ram_rdata;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lanes at or above the offset come from the first word; the rest from the second.
  always_comb begin
    lo_sel = split ? mask1 : 4'b0000;
    merged = 32'h0;
    for (int k = 0; k < 4; k++) begin
      merged[8*k +: 8] = lo_sel[k] ? lo_buf_q[8*k +: 8] : ram_rdata[8*k +: 8];
    end
    aligned = rotl_lanes(merged, 2'd0 - cs_q);
    case (mode_q)
      MODE_B:  load_data = {{24{~uns_q & aligned[7]}}, aligned[7:0]};
      MODE_H:  load_data = {{16{~uns_q & aligned[15]}}, aligned[15:0]};
      default: load_data = aligned;
    endcase
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = 32'h0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'h0;
    case (state_q)
      A1: begin
        ram_en    = 1'b1;
        ram_addr  = waddr_q;
        ram_we    = we_q ? mask1 : 4'b0000;
        ram_wdata = wdata_q;
      end
      A2: begin
        ram_en    = 1'b1;
        ram_addr  = waddr_q + (AW-2)'(1);
        ram_we    = we_q ? mask2 : 4'b0000;
        ram_wdata = wdata_q;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = we_q ? 32'h0 : load_data;
      end
      ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
